// File: rtl/timer_regs_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : timer_regs_pkg
//  Purpose : Register map of the interval timer slave port (address
//            constants, control bit indices, ready-made control words) and
//            the state encoding of the timer tick sequencer.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package timer_regs_pkg;

  // Timer slave register addresses
  localparam logic [2:0] TIMER_ADDR_STATUS  = 3'd0;
  localparam logic [2:0] TIMER_ADDR_CONTROL = 3'd1;
  localparam logic [2:0] TIMER_ADDR_PERIODL = 3'd2;
  localparam logic [2:0] TIMER_ADDR_PERIODH = 3'd3;
  localparam logic [2:0] TIMER_ADDR_SNAPL   = 3'd4;
  localparam logic [2:0] TIMER_ADDR_SNAPH   = 3'd5;

  // Control register bit indices
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // Control words: run continuously with interrupts, or stop with ITO cleared
  localparam logic [15:0] C_CTL_WORD_START =
      (16'd1 << CTL_START) | (16'd1 << CTL_CONT) | (16'd1 << CTL_ITO);
  localparam logic [15:0] C_CTL_WORD_STOP  = (16'd1 << CTL_STOP);

  // Sequencer states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR0 = 3'd1,
    ST_WPL  = 3'd2,
    ST_WPH  = 3'd3,
    ST_WCTL = 3'd4,
    ST_RUN  = 3'd5,
    ST_ACK  = 3'd6,
    ST_STOP = 3'd7
  } tts_state_e;

endpackage : timer_regs_pkg
`default_nettype wire

// File: rtl/timer_tick_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : timer_tick_sequencer
//  Purpose : Bus master that programs the interval timer (status clear,
//            period low/high, control start) when enable rises, then
//            acknowledges every timeout interrupt and emits a one-cycle tick
//            with a wrapping tick counter. Stops the timer when enable drops.
//  Ports   : clk, reset      - clock, synchronous active-high reset
//            enable          - level, run request
//            irq             - timer interrupt
//            address, chipselect, write_n, writedata - timer write port
//            tick            - one-cycle pulse per serviced timeout
//            tick_count      - serviced timeouts since reset (wraps)
//            running         - timer configured and counting
//  Rev     : 1.0  initial release
// ============================================================================
module timer_tick_sequencer
  import timer_regs_pkg::*;
#(
  parameter logic [31:0] PERIOD = 32'd49999,
  parameter int          TICK_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              irq,
  output logic [2:0]        address,
  output logic              chipselect,
  output logic              write_n,
  output logic [15:0]       writedata,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              running
);

  tts_state_e        state_q, state_d;
  logic [TICK_W-1:0] tick_count_q;

  // Next-state logic. enable/irq are only looked at in IDLE and RUN, so a
  // configuration or acknowledge sequence always completes once started.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_CLR0;
      ST_CLR0: state_d = ST_WPL;
      ST_WPL:  state_d = ST_WPH;
      ST_WPH:  state_d = ST_WCTL;
      ST_WCTL: state_d = ST_RUN;
      // Stop has priority over a coincident interrupt; the pending flag is
      // cleared by CLR0 on the next start.
      ST_RUN: begin
        if (!enable)  state_d = ST_STOP;
        else if (irq) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_RUN;
      ST_STOP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tick_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ACK) tick_count_q <= tick_count_q + TICK_W'(1);
    end
  end

  // Outputs are decoded from the state register only, so no input reaches
  // an output combinationally. Idle bus holds address/data at zero.
  always_comb begin
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 16'h0000;
    tick       = 1'b0;
    running    = 1'b0;
    case (state_q)
      ST_CLR0: begin
        address    = TIMER_ADDR_STATUS;
        chipselect = 1'b1;
        write_n    = 1'b0;
      end
      ST_WPL: begin
        address    = TIMER_ADDR_PERIODL;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = PERIOD[15:0];
      end
      ST_WPH: begin
        address    = TIMER_ADDR_PERIODH;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = PERIOD[31:16];
      end
      ST_WCTL: begin
        address    = TIMER_ADDR_CONTROL;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = C_CTL_WORD_START;
      end
      ST_RUN: begin
        running = 1'b1;
      end
      // Status write clears the timeout flag; the timer keeps counting.
      ST_ACK: begin
        address    = TIMER_ADDR_STATUS;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick       = 1'b1;
        running    = 1'b1;
      end
      ST_STOP: begin
        address    = TIMER_ADDR_CONTROL;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = C_CTL_WORD_STOP;
      end
      default: ;
    endcase
  end

  assign tick_count = tick_count_q;

endmodule : timer_tick_sequencer
`default_nettype wire

// File: doc/timer_tick_sequencer.md
# timer_tick_sequencer

Hardware bus master that programs and services the design's interval timer peripheral, which has a 16-bit register-mapped slave port. Once `enable` is raised, it writes the timer's period and control registers, then waits for each timeout interrupt and acknowledges it. For every acknowledged timeout it produces a one-cycle `tick` and a wrapping tick count. It drives the game logic's fixed-rate update (ball/paddle step) with no CPU involvement.

## Interface
Parameters:
- `PERIOD`, 32'd49999, timer load value; tick interval is PERIOD+1 clocks (1 ms at 50 MHz)
- `TICK_W`, 16, width of `tick_count`

Ports:
- `clk`  in  1  system clock, shared with the timer
- `reset`  in  1  synchronous, active-high reset
- `enable`  in  1  level; high = run the timer, low = stop it
- `irq`  in  1  timer interrupt (timeout flag AND interrupt enable)
- `address`  out  3  timer register address
- `chipselect`  out  1  timer slave select
- `write_n`  out  1  active-low write strobe
- `writedata`  out  16  timer write data
- `tick`  out  1  one-cycle pulse per serviced timeout
- `tick_count`  out  TICK_W  serviced timeouts since reset, wraps
- `running`  out  1  high while the timer is configured and counting

## Operation
- Timer register map: 0 status (any write clears the timeout flag), 1 control, 2 period low, 3 period high. Control bits: 0 ITO, 1 CONT, 2 START, 3 STOP.
- The timer accepts zero-wait-state writes. Each bus write is exactly one cycle with `chipselect`=1 and `write_n`=0. There are no reads.
- FSM states:
  - IDLE: bus idle. If `enable`=1 → CLR0.
  - CLR0: write addr 0, data 0x0000. Clears any stale interrupt. → WPL.
  - WPL: write addr 2, data PERIOD[15:0]. → WPH.
  - WPH: write addr 3, data PERIOD[31:16]. → WCTL.
  - WCTL: write addr 1, data 0x0007 (START|CONT|ITO). → RUN.
  - RUN: bus idle, `running`=1. If `enable`=0 → STOP. Else if `irq`=1 → ACK. Otherwise stay.
  - ACK: write addr 0, data 0x0000, `tick`=1. `tick_count` increments at the end of the cycle. → RUN.
  - STOP: write addr 1, data 0x0008 (STOP, ITO cleared). → IDLE.
- `enable` is sampled only in IDLE and RUN. A drop during CLR0..WCTL finishes the configuration, then RUN sees it and goes to STOP. A drop in ACK finishes ACK, then STOP.
- In RUN, `enable`=0 and `irq`=1 in the same cycle: stop wins and no tick is issued. The pending flag is cleared by CLR0 at the next enable.
- `tick_count` wraps from 2^TICK_W−1 to 0 with no flag.
- A sync `reset` mid-operation forces IDLE. The timer is not reset and may keep running. The next enable reprograms it: the period writes force a reload and a stop, then WCTL restarts it.

## Timing
- Reset values: `address`=0, `chipselect`=0, `write_n`=1, `writedata`=0, `tick`=0, `tick_count`=0, `running`=0.
- All outputs are decoded from registered state only. There is no combinational path from `irq` or `enable` to any output.
- Startup: `enable` rises in cycle N (IDLE) → CLR0 at N+1, WPL N+2, WPH N+3, WCTL N+4, RUN from N+5 (`running`=1).
- Timer counting starts the clock after the WCTL write. First `irq` is PERIOD+1..PERIOD+2 cycles later.
- Service: `irq` high in RUN cycle M → ACK in M+1 (`tick`=1, status write). `irq` and `tick` are low and `tick_count` is updated in M+2.
- Steady state: exactly one tick per PERIOD+1 clocks. Servicing takes 2 cycles, so PERIOD ≥ 2 is required.
- When idle, `chipselect`=0, `write_n`=1, and `address`/`writedata` are held at 0.

## Structure
- Shared package `timer_regs_pkg`:
  - address constants TIMER_ADDR_STATUS/CONTROL/PERIODL/PERIODH/SNAPL/SNAPH (0..5)
  - control bit indices CTL_ITO/CTL_CONT/CTL_START/CTL_STOP
  - this block's state enum
- Single module, no sub-modules. The `tick_count` counter sits inline.

## Test plan
- Bench with the real timer, PERIOD=9. Reset, hold `enable`=1 → writes (0,0x0000), (2,0x0009), (3,0x0000), (1,0x0007) on consecutive cycles; `running`=1 after the fourth.
- Same setup, run 100 ticks → `tick` pulses spaced exactly 10 cycles apart; `tick_count`=100; `irq` never high more than 1 cycle.
- TICK_W=4, run 17 ticks → `tick_count` reads 15 then 0 then 1.
- Drop `enable` during WPH → WCTL still written, one RUN cycle, then write (1,0x0008); IDLE; timer `running` bit clears; no further ticks.
- Force `irq`=1 and `enable`=0 in the same RUN cycle → STOP write, `tick` stays 0, `tick_count` unchanged. Re-enable → CLR0 clears the stale flag before reprogramming.
- Assert `reset` for 1 cycle mid-RUN, keep `enable`=1 → all outputs at reset values next cycle; full 4-write sequence reissued; ticks resume with `tick_count` from 0.
